// File: rtl/ram512k_pkg.sv
// ram512k_pkg: shared mode encodings, FSM state types and select prefix for the 512K bank controller
package ram512k_pkg;
  localparam logic [2:0] MODE_OFF  = 3'd0;
  localparam logic [2:0] MODE_C3   = 3'd1;
  localparam logic [2:0] MODE_ALL  = 3'd2;
  localparam logic [2:0] MODE_C3B  = 3'd3;
  localparam logic [2:0] MODE_W4   = 3'd4;
  localparam logic [1:0] SEL_PREFIX = 2'b11;
  typedef enum logic [1:0] {IO_IDLE, IO_QUAL, IO_DONE} io_state_t;
  typedef enum logic [1:0] {M_IDLE, M_EXT, M_INT} mem_state_t;
endpackage

// File: rtl/ram512k_map.sv
// ram512k_map: combinational bank map from {ccc,bbb} and {A15,A14} to expansion hit and SRAM A[18:14]
//   bank  : committed {ccc,bbb}
//   a     : {A15,A14} of the access
//   hit   : access goes to the expansion SRAM
//   adrhi : SRAM A[18:14] for a hit
module ram512k_map
  import ram512k_pkg::*;
#(
  parameter int NUM_BANKS = 8
) (
  input  logic [5:0] bank,
  input  logic [1:0] a,
  output logic       hit,
  output logic [4:0] adrhi
);
  logic [2:0] m;
  logic [2:0] c;
  logic       raw;
  assign m = bank[2:0];
  assign c = bank[5:3];
  always_comb begin
    raw = (m >= MODE_W4) ? (a == 2'b01) :
          (m == MODE_ALL) ? 1'b1 :
          (m == MODE_C3 || m == MODE_C3B) ? (a == 2'b11) : 1'b0;
    adrhi = {c, (m >= MODE_W4) ? m[1:0] : (m == MODE_ALL) ? a : 2'b11};
    // unpopulated 64K blocks fall back to internal RAM
    hit = raw && (32'(c) < NUM_BANKS);
  end
endmodule

// File: rtl/ram512k_bank_ctrl.sv
// ram512k_bank_ctrl: bank-select I/O decoder and registered SRAM access sequencer for the 512K expansion
//   clk, reset           : card clock, synchronous active-high reset
//   adr15, adr14, data   : CPC address/data, sampled directly
//   iorq_b, mreq_b, wr_b : async Z80 strobes, synchronized
//   ramcs_b, ramdis, ramadrhi : registered SRAM/internal RAM controls
//   bank_q, cfg_commit   : committed bank register and its update pulse
module ram512k_bank_ctrl
  import ram512k_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int QUAL_CYCLES = 2,
  parameter int NUM_BANKS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adr15,
  input  logic       adr14,
  input  logic       iorq_b,
  input  logic       mreq_b,
  input  logic       wr_b,
  input  logic [7:0] data,
  output logic       ramcs_b,
  output logic       ramdis,
  output logic [4:0] ramadrhi,
  output logic [5:0] bank_q,
  output logic       cfg_commit
);
  localparam int CW = $clog2(QUAL_CYCLES + 1);
  logic          iorq_s, mreq_s, wr_s, mreq_d;
  logic          valid_wr, req, pending, commit_now, hit;
  logic [5:0]    cap, pend_val;
  logic [4:0]    adrhi;
  logic [CW-1:0] cnt, cnt_nx;
  io_state_t     io_st;
  mem_state_t    mem_st;
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    logic [2:0] q;
    if (i == 0) begin : g_first
      always_ff @(posedge clk) q <= reset ? 3'b111 : {iorq_b, mreq_b, wr_b};
    end else begin : g_next
      always_ff @(posedge clk) q <= reset ? 3'b111 : g_sync[i-1].q;
    end
  end
  assign {iorq_s, mreq_s, wr_s} = g_sync[SYNC_STAGES-1].q;
  assign valid_wr = !iorq_s && !wr_s && !adr15 && data[7:6] == SEL_PREFIX;
  assign cnt_nx = cnt + CW'(1);
  always_ff @(posedge clk)
    if (reset) begin
      io_st <= IO_IDLE;
      cnt   <= '0;
      cap   <= '0;
      req   <= 1'b0;
    end else begin
      req <= 1'b0;
      case (io_st)
        IO_IDLE: if (valid_wr) begin
          cap   <= data[5:0];
          cnt   <= CW'(1);
          io_st <= (QUAL_CYCLES == 1) ? IO_DONE : IO_QUAL;
          req   <= (QUAL_CYCLES == 1);
        end
        // the value must stay identical for every qualifying sample
        IO_QUAL: if (!valid_wr || data[5:0] != cap) io_st <= IO_IDLE;
          else begin
            cnt <= cnt_nx;
            if (32'(cnt_nx) == QUAL_CYCLES) begin
              io_st <= IO_DONE;
              req   <= 1'b1;
            end
          end
        // wait for the I/O cycle to end so a long strobe commits only once
        IO_DONE: if (iorq_s) io_st <= IO_IDLE;
        default: io_st <= IO_IDLE;
      endcase
    end
  // a fresh request in an idle cycle supersedes any pending value
  assign commit_now = (mem_st == M_IDLE) && (req || pending);
  always_ff @(posedge clk)
    if (reset) begin
      bank_q     <= '0;
      pend_val   <= '0;
      pending    <= 1'b0;
      cfg_commit <= 1'b0;
    end else begin
      cfg_commit <= commit_now;
      if (commit_now) begin
        bank_q  <= req ? cap : pend_val;
        pending <= 1'b0;
      end else if (req) begin
        pending  <= 1'b1;
        pend_val <= cap;
      end
    end
  ram512k_map #(.NUM_BANKS(NUM_BANKS)) u_map (
    .bank  (bank_q),
    .a     ({adr15, adr14}),
    .hit   (hit),
    .adrhi (adrhi)
  );
  // map is evaluated once on the mreq edge; outputs are then frozen until the cycle ends
  always_ff @(posedge clk)
    if (reset) begin
      mem_st   <= M_IDLE;
      mreq_d   <= 1'b1;
      ramcs_b  <= 1'b1;
      ramdis   <= 1'b0;
      ramadrhi <= '0;
    end else begin
      mreq_d <= mreq_s;
      case (mem_st)
        M_IDLE: if (!mreq_s && mreq_d) begin
          mem_st <= hit ? M_EXT : M_INT;
          if (hit) begin
            ramadrhi <= adrhi;
            ramcs_b  <= 1'b0;
            ramdis   <= 1'b1;
          end
        end
        M_EXT: if (mreq_s) begin
          ramcs_b <= 1'b1;
          ramdis  <= 1'b0;
          mem_st  <= M_IDLE;
        end
        M_INT: if (mreq_s) mem_st <= M_IDLE;
        default: mem_st <= M_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ram512k_bank_ctrl.sv
// tb_ram512k_bank_ctrl: directed and random checks of the bank controller against a behavioural model
module tb_ram512k_bank_ctrl;
  localparam int S = 2;
  localparam int Q = 2;
  logic clk = 1'b0;
  logic reset, adr15, adr14, iorq_b, mreq_b, wr_b;
  logic [7:0] data;
  logic cs8, dis8, cc8, cs4, dis4, cc4;
  logic [4:0] adr8, adr4;
  logic [5:0] bq8, bq4;
  logic [7:0] st8, st4;
  int n_assert = 0;
  int n_fail = 0;
  int nc8 = 0;
  int nc4 = 0;
  logic [5:0] mbank;
  logic [4:0] last8, last4;
  always #5 clk = ~clk;
  ram512k_bank_ctrl #(.SYNC_STAGES(S), .QUAL_CYCLES(Q), .NUM_BANKS(8)) dut (
    .clk(clk), .reset(reset), .adr15(adr15), .adr14(adr14), .iorq_b(iorq_b),
    .mreq_b(mreq_b), .wr_b(wr_b), .data(data), .ramcs_b(cs8), .ramdis(dis8),
    .ramadrhi(adr8), .bank_q(bq8), .cfg_commit(cc8)
  );
  ram512k_bank_ctrl #(.SYNC_STAGES(S), .QUAL_CYCLES(Q), .NUM_BANKS(4)) dut4 (
    .clk(clk), .reset(reset), .adr15(adr15), .adr14(adr14), .iorq_b(iorq_b),
    .mreq_b(mreq_b), .wr_b(wr_b), .data(data), .ramcs_b(cs4), .ramdis(dis4),
    .ramadrhi(adr4), .bank_q(bq4), .cfg_commit(cc4)
  );
  assign st8 = {1'b0, cs8, dis8, adr8};
  assign st4 = {1'b0, cs4, dis4, adr4};
  always @(posedge clk) begin
    if (cc8 === 1'b1) nc8++;
    if (cc4 === 1'b1) nc4++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void ref_map(input logic [5:0] b, input logic [1:0] a, input int nb,
                                  output bit hit, output logic [4:0] adr);
    int c, m, al;
    c = int'(b[5:3]);
    m = int'(b[2:0]);
    al = int'(a);
    hit = 1'b0;
    adr = '0;
    if (m == 1 || m == 3) begin hit = (al == 3); adr = 5'(c * 4 + 3); end
    else if (m == 2) begin hit = 1'b1; adr = 5'(c * 4 + al); end
    else if (m >= 4) begin hit = (al == 1); adr = 5'(c * 4 + m - 4); end
    if (c >= nb) hit = 1'b0;
  endfunction
  task automatic io_wr(input bit a15, input logic [7:0] d, input int hold);
    adr15 = a15; data = d; iorq_b = 1'b0; wr_b = 1'b0;
    tick(hold);
    iorq_b = 1'b1; wr_b = 1'b1;
    tick(S + Q + 4);
  endtask
  task automatic io_expect(input string tag, input bit a15, input logic [7:0] d, input int hold);
    int c8, c4;
    bit ok;
    c8 = nc8; c4 = nc4;
    io_wr(a15, d, hold);
    ok = !a15 && d[7:6] == 2'b11 && hold >= Q;
    if (ok) mbank = d[5:0];
    check({tag, "_commits8"}, 8'(nc8 - c8), ok ? 8'd1 : 8'd0);
    check({tag, "_commits4"}, 8'(nc4 - c4), ok ? 8'd1 : 8'd0);
    check({tag, "_bank8"}, {2'b0, bq8}, {2'b0, mbank});
    check({tag, "_bank4"}, {2'b0, bq4}, {2'b0, mbank});
  endtask
  task automatic mem_acc(input string tag, input bit a15, input bit a14, input int len);
    bit h8, h4;
    logic [4:0] m8, m4;
    logic [7:0] pre8, pre4, on8, on4, off8, off4;
    ref_map(mbank, {a15, a14}, 8, h8, m8);
    ref_map(mbank, {a15, a14}, 4, h4, m4);
    pre8 = {3'b010, last8};
    pre4 = {3'b010, last4};
    on8 = h8 ? {3'b001, m8} : pre8;
    on4 = h4 ? {3'b001, m4} : pre4;
    off8 = {3'b010, h8 ? m8 : last8};
    off4 = {3'b010, h4 ? m4 : last4};
    adr15 = a15; adr14 = a14; mreq_b = 1'b0;
    tick(S);
    check({tag, "_pre8"}, st8, pre8);
    check({tag, "_pre4"}, st4, pre4);
    tick(1);
    check({tag, "_on8"}, st8, on8);
    check({tag, "_on4"}, st4, on4);
    tick(len);
    check({tag, "_hold8"}, st8, on8);
    check({tag, "_hold4"}, st4, on4);
    mreq_b = 1'b1;
    tick(S);
    check({tag, "_tail8"}, st8, on8);
    tick(1);
    check({tag, "_off8"}, st8, off8);
    check({tag, "_off4"}, st4, off4);
    if (h8) last8 = m8;
    if (h4) last4 = m4;
    tick(2);
  endtask
  initial begin
    int c8;
    logic [7:0] d;
    reset = 1'b1; adr15 = 1'b0; adr14 = 1'b0; iorq_b = 1'b1; mreq_b = 1'b1; wr_b = 1'b1;
    data = 8'h00; mbank = '0; last8 = '0; last4 = '0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_st8", st8, 8'h40);
    check("reset_st4", st4, 8'h40);
    check("reset_bank", {2'b0, bq8}, 8'h00);
    check("reset_commit", {7'b0, cc8}, 8'h00);
    mem_acc("bank0", 1'b1, 1'b1, 3);
    io_expect("c2", 1'b0, 8'hC2, 4);
    mem_acc("c2_8000", 1'b1, 1'b0, 4);
    io_expect("fd", 1'b0, 8'hFD, 3);
    mem_acc("fd_4000", 1'b0, 1'b1, 2);
    io_expect("glitch", 1'b0, 8'hC5, 1);
    io_expect("hi_adr", 1'b1, 8'hC4, 4);
    io_expect("noprefix", 1'b0, 8'h85, 4);
    io_expect("long", 1'b0, 8'hC3, 10);
    io_expect("c2b", 1'b0, 8'hC2, 4);
    adr15 = 1'b1; adr14 = 1'b1; mreq_b = 1'b0;
    tick(S + 1);
    check("defer_on", st8, 8'h23);
    c8 = nc8;
    io_wr(1'b0, 8'hC1, 4);
    check("defer_bank_held", {2'b0, bq8}, 8'h02);
    check("defer_no_commit", 8'(nc8 - c8), 8'd0);
    check("defer_adr_held", st8, 8'h23);
    mreq_b = 1'b1;
    tick(S + 1);
    check("defer_off", st8, 8'h43);
    tick(3);
    check("defer_bank", {2'b0, bq8}, 8'h01);
    check("defer_commits", 8'(nc8 - c8), 8'd1);
    mbank = 6'h01; last8 = 5'b00011; last4 = 5'b00011;
    io_expect("c2c", 1'b0, 8'hC2, 4);
    adr15 = 1'b1; adr14 = 1'b1; mreq_b = 1'b0;
    tick(S + 1);
    check("rstmid_on", st8, 8'h23);
    io_wr(1'b0, 8'hC1, 4);
    check("rstmid_pend", {2'b0, bq8}, 8'h02);
    c8 = nc8;
    reset = 1'b1;
    tick(1);
    check("rstmid_st8", st8, 8'h40);
    check("rstmid_bank", {2'b0, bq8}, 8'h00);
    check("rstmid_cc", {7'b0, cc8}, 8'h00);
    mreq_b = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("rstmid_no_commit", 8'(nc8 - c8), 8'd0);
    check("rstmid_bank_after", {2'b0, bq8}, 8'h00);
    mbank = '0; last8 = '0; last4 = '0;
    for (int i = 0; i < 25; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
      io_expect("rnd_io", $urandom_range(0, 4) == 0, d, int'($urandom_range(1, 4)));
      mem_acc("rnd_mem", 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
